// File: rtl/lif_frame_feeder.sv
// lif_frame_feeder
//   Packs T per-timestep accumulator beats into the T*Q membrane-input vector
//   of one LIF neuron. It starts one LIF evaluation per frame, waits for the
//   LIF done pulse, and hands the captured T-bit spike train downstream over
//   a valid/ready port.
//
// Optional build macro: LIF_FEEDER_SAT_EN
//   Defined   : a beat is quantised by unsigned saturation to 2^Q-1.
//   Undefined : a beat is quantised by truncation to in_data[Q-1:0].
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     accumulator beat stream (ACC_W bits)
//   lif_start, lif_result_val     one-cycle frame start to the LIF
//   lif_input_data                packed slots; timestep k at [(k+1)*Q-1:k*Q]
//   lif_spike_out, lif_done       spike train and done pulse from the LIF
//   out_valid/out_ready/out_spikes  spike train to downstream logic
//   frame_cnt                     completed frames, wraps at 2^16
//   err_spurious_done             sticky flag: lif_done seen outside WAIT
module lif_frame_feeder #(
    parameter int T     = 8,
    parameter int Q     = 10,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data,
    output logic             lif_start,
    output logic             lif_result_val,
    output logic [T*Q-1:0]   lif_input_data,
    input  logic [T-1:0]     lif_spike_out,
    input  logic             lif_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [T-1:0]     out_spikes,
    output logic [15:0]      frame_cnt,
    output logic             err_spurious_done
);

    localparam int IDX_W = (T > 1) ? $clog2(T) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(T - 1);

    typedef enum logic [1:0] {FILL, ISSUE, WAIT, OUT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [T*Q-1:0]   pack;
    logic [Q-1:0]     qval;
    logic             accept;

`ifdef LIF_FEEDER_SAT_EN
    always_comb begin
        qval = in_data[Q-1:0];
        if (in_data > ACC_W'((1 << Q) - 1))
            qval = '1;
    end
`else
    always_comb qval = in_data[Q-1:0];
`endif

    // The LIF reads the packing register directly through its CALC phase.
    assign lif_input_data = pack;

    always_ff @(posedge clk) begin
        if (rst)
            state <= FILL;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        // in_ready is gated by rst so that it stays low in the reset cycle
        // even when the FSM happens to be in FILL.
        in_ready       = 1'b0;
        lif_start      = 1'b0;
        lif_result_val = 1'b0;
        out_valid      = 1'b0;
        case (state)
            FILL: begin
                in_ready = !rst;
                if (in_valid && idx == LAST_IDX)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                lif_start      = 1'b1;
                lif_result_val = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT: begin
                if (lif_done)
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx               <= '0;
            pack              <= '0;
            out_spikes        <= '0;
            frame_cnt         <= '0;
            err_spurious_done <= 1'b0;
        end else begin
            if (accept) begin
                for (int unsigned k = 0; k < T; k++) begin
                    if (idx == IDX_W'(k))
                        pack[k*Q +: Q] <= qval;
                end
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            if (state == WAIT && lif_done)
                out_spikes <= lif_spike_out;
            if (state == OUT && out_ready)
                frame_cnt <= frame_cnt + 16'd1;
            if (lif_done && state != WAIT)
                err_spurious_done <= 1'b1;
        end
    end

endmodule

// File: doc/lif_frame_feeder.md
# lif_frame_feeder

Producer-side companion to the LIF neuron. Accepts a stream of per-timestep accumulator results, packs T of them into the T*Q membrane-input vector, and issues one LIF evaluation per frame via the LIF start/result_val handshake. It then waits for the LIF done pulse and returns the captured T-bit spike train to downstream logic over a valid/ready port. One instance sits between the PE accumulator output and each LIF neuron.

## Interface
- T, 8, timesteps per frame (≥2)
- Q, 10, quantised membrane-input width
- ACC_W, 16, accumulator result width (≥Q)

- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  accumulator beat valid
- in_ready  out  1  feeder accepts a beat
- in_data  in  ACC_W  unsigned accumulator value for the current timestep
- lif_start  out  1  to LIF start
- lif_result_val  out  1  to LIF result_val
- lif_input_data  out  T*Q  to LIF input_data; timestep k occupies bits [(k+1)*Q-1 : k*Q]
- lif_spike_out  in  T  from LIF spike_out
- lif_done  in  1  from LIF done pulse
- out_valid  out  1  spike train available
- out_ready  in  1  downstream accepts spike train
- out_spikes  out  T  captured spike train, bit k = timestep k
- frame_cnt  out  16  completed frames, wraps at 2^16
- err_spurious_done  out  1  sticky: lif_done seen outside WAIT

## Operation
- FSM states: FILL, ISSUE, WAIT, OUT. Reset → FILL.
- FILL: in_ready=1. Beat accepted when in_valid&in_ready; quantised value written to slot idx, idx++. Accepting beat with idx==T-1 → ISSUE, idx←0.
- Quantisation: without macro, value = in_data[Q-1:0].
- ISSUE (exactly one cycle): lif_start=1, lif_result_val=1, in_ready=0 → WAIT.
- WAIT: in_ready=0; lif_input_data held stable (LIF reads it through CALC). On lif_done: capture lif_spike_out into out_spikes → OUT.
- OUT: out_valid=1, out_spikes stable. On out_ready: frame_cnt++ → FILL.
- lif_done in FILL/ISSUE/OUT: ignored for FSM, sets err_spurious_done (cleared only by rst).
- lif_input_data is the packing register directly; no other register in that path.

## Timing
- Reset values: in_ready=0 in the reset cycle, 1 from the first cycle after; lif_start=0, lif_result_val=0, lif_input_data=0, out_valid=0, out_spikes=0, frame_cnt=0, err_spurious_done=0, idx=0.
- lif_start/lif_result_val are Moore outputs of ISSUE: high exactly one cycle per frame.
- Against the LIF (IDLE→CALC, T+1 CALC cycles, DONE) lif_done arrives T+2 cycles after ISSUE; feeder makes no assumption and waits indefinitely.
- lif_done sampled in WAIT → out_valid high next cycle.
- out_ready sampled in OUT → in_ready high next cycle; zero-bubble per handshake, minimum frame period T+1+(LIF latency)+2 cycles.
- in_valid while in_ready=0: no beat consumed, in_data ignored.
- rst mid-frame: FSM→FILL, partial slots and idx discarded (slots zeroed), out_valid dropped; an in-flight LIF frame's later done pulse sets err_spurious_done.
- frame_cnt 0xFFFF + 1 → 0x0000.

## Configuration
- LIF_FEEDER_SAT_EN defined: value = (in_data > 2^Q-1) ? 2^Q-1 : in_data[Q-1:0] (unsigned saturation).
- Undefined: plain truncation to in_data[Q-1:0]. No other behaviour differs.

## Test plan
- Basic frame: T=8, Q=10, beats 1..8 back-to-back, LIF model threshold 5 → lif_start one cycle after 8th beat, lif_input_data slot k = k+1, out_spikes captured from LIF, out_valid held until out_ready, frame_cnt=1.
- Backpressure: out_ready low 20 cycles in OUT → out_spikes stable, in_ready=0 throughout, frame_cnt increments only on out_ready cycle.
- Saturation: in_data=0x0500 in slot 3 → slot 3 = 0x3FF with LIF_FEEDER_SAT_EN, 0x100 without.
- Gapped input: in_valid toggled every other cycle → exactly 8 beats packed in order, no ISSUE before 8th.
- Spurious done: pulse lif_done during FILL → err_spurious_done=1 and stays, FSM remains in FILL, idx unchanged.
- Reset mid-WAIT: assert rst 1 cycle during WAIT → all outputs at reset values next cycle, subsequent full frame processes normally, late done from old frame sets err_spurious_done.
